// File: rtl/qdiv.sv
// Signed fixed-point divider: restoring shift-subtract, one quotient bit per cycle.
// Free-running: operands are captured on every IDLE edge, and saturation is flagged on warn.
module qdiv #(
  parameter int unsigned WIDTH = 31,
  parameter int unsigned FBITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH:0]   dividend,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH:0]   quotient,
  output logic             valid,
  output logic             warn,
  output logic             busy
);

  localparam int unsigned N  = WIDTH + 1 + FBITS;
  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic             sign_q, sign_d;
  logic             dmsb_q, dmsb_d;
  logic [WIDTH:0]   mb_q, mb_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [N-1:0]     num_q, num_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   quotient_q, quotient_d;
  logic             warn_q, warn_d;
  logic             valid_q, valid_d;

  logic [WIDTH:0]   mag_a;
  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH+1:0] rem_sub;
  logic             ovf_pos, ovf_neg;
  logic [WIDTH:0]   sat_pos, sat_neg;

  assign sat_pos = {1'b0, {WIDTH{1'b1}}};
  assign sat_neg = {1'b1, {WIDTH{1'b0}}};

  // Magnitude limits: +(2^W - 1) for positive results, 2^W for negative ones.
  assign ovf_pos = |quo_q[N-1:WIDTH];
  assign ovf_neg = (|quo_q[N-1:WIDTH+1]) | (quo_q[WIDTH] & (|quo_q[WIDTH-1:0]));

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    dmsb_d     = dmsb_q;
    mb_d       = mb_q;
    rem_d      = rem_q;
    num_d      = num_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    quotient_d = quotient_q;
    warn_d     = warn_q;
    valid_d    = 1'b0;
    mag_a      = dividend[WIDTH] ? (~dividend + 1'b1) : dividend;
    rem_shift  = {rem_q, num_q[N-1]};
    rem_sub    = rem_shift - {1'b0, mb_q};

    unique case (state_q)
      StIdle: begin
        sign_d  = dividend[WIDTH] ^ divisor[WIDTH];
        dmsb_d  = dividend[WIDTH];
        mb_d    = divisor[WIDTH] ? (~divisor + 1'b1) : divisor;
        num_d   = {mag_a, {FBITS{1'b0}}};
        rem_d   = '0;
        quo_d   = '0;
        cnt_d   = '0;
        state_d = StCalc;
      end
      StCalc: begin
        if (rem_shift >= {1'b0, mb_q}) begin
          rem_d = rem_sub[WIDTH:0];
          quo_d = {quo_q[N-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH:0];
          quo_d = {quo_q[N-2:0], 1'b0};
        end
        num_d = num_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = StDone;
      end
      StDone: begin
        valid_d = 1'b1;
        state_d = StIdle;
        if (mb_q == '0) begin
          warn_d     = 1'b1;
          quotient_d = dmsb_q ? sat_neg : sat_pos;
        end else if (sign_q ? ovf_neg : ovf_pos) begin
          warn_d     = 1'b1;
          quotient_d = sign_q ? sat_neg : sat_pos;
        end else begin
          warn_d     = 1'b0;
          quotient_d = sign_q ? (~quo_q[WIDTH:0] + 1'b1) : quo_q[WIDTH:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= StIdle;
      sign_q     <= 1'b0;
      dmsb_q     <= 1'b0;
      mb_q       <= '0;
      rem_q      <= '0;
      num_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      quotient_q <= '0;
      warn_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      dmsb_q     <= dmsb_d;
      mb_q       <= mb_d;
      rem_q      <= rem_d;
      num_q      <= num_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      quotient_q <= quotient_d;
      warn_q     <= warn_d;
      valid_q    <= valid_d;
    end
  end

  assign quotient = quotient_q;
  assign warn     = warn_q;
  assign valid    = valid_q;
  assign busy     = (state_q == StCalc);

endmodule

// File: tb/tb_qdiv.sv
// Bench for qdiv: directed and random divisions against a 64-bit arithmetic reference,
// plus latency, hold, mid-calc operand change and mid-calc reset behaviour.
module tb_qdiv;

  localparam int WIDTH = 31;
  localparam int FBITS = 16;
  localparam int LAT   = 49;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] quotient;
  logic        valid, warn, busy;

  int          n_pass = 0;
  int          n_total = 0;
  logic        overlap = 1'b0;
  logic [31:0] prev_q = '0;
  logic        prev_w = 1'b0;

  always #5 clk = ~clk;

  qdiv #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .valid    (valid),
    .warn     (warn),
    .busy     (busy)
  );

  always @(negedge clk) if (valid && busy) overlap = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Q15.16 signed division from plain integer arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic w);
    logic [63:0] ma, mb, mq, neg_q;
    logic        neg;
    neg = a[31] ^ b[31];
    ma  = a[31] ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
    mb  = b[31] ? (64'h1_0000_0000 - {32'h0, b}) : {32'h0, b};
    if (mb == 64'h0) begin
      w = 1'b1;
      q = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      mq = (ma << FBITS) / mb;
      if ((!neg && mq > 64'h7FFF_FFFF) || (neg && mq > 64'h8000_0000)) begin
        w = 1'b1;
        q = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        w     = 1'b0;
        neg_q = 64'h0 - mq;
        q     = neg ? neg_q[31:0] : mq[31:0];
      end
    end
  endfunction

  // Called when the next rising edge is an IDLE capture edge.
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input bit chg, input logic [31:0] ca, input logic [31:0] cb);
    logic [31:0] eq;
    logic        ew;
    int          k;
    bit          seen;
    model(a, b, eq, ew);
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    k = 1;
    check({tag, "_busy_after_capture"}, 64'(busy), 64'd1);
    check({tag, "_valid_one_cycle"}, 64'(valid), 64'd0);
    seen = 1'b0;
    while (k < 200 && !seen) begin
      @(posedge clk); #1;
      k++;
      if (k == 11 && chg) begin
        dividend = ca;
        divisor  = cb;
      end
      if (k == 20) check({tag, "_hold_quotient"}, 64'(quotient), 64'(prev_q));
      if (valid) seen = 1'b1;
    end
    check({tag, "_valid_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(k - 1), 64'(LAT));
    check({tag, "_quotient"}, 64'(quotient), 64'(eq));
    check({tag, "_warn"}, 64'(warn), 64'(ew));
    prev_q = eq;
    prev_w = ew;
  endtask

  initial begin
    logic [31:0] ra, rb;
    #1;
    check("reset_quotient", 64'(quotient), 64'd0);
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_warn", 64'(warn), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;

    run("div_8_by_2",   32'h0008_0000, 32'h0002_0000, 1'b0, '0, '0);
    check("div_8_by_2_exact", 64'(quotient), 64'h0004_0000);
    run("div_7_by_3",   32'h0007_0000, 32'h0003_0000, 1'b0, '0, '0);
    check("div_7_by_3_exact", 64'(quotient), 64'h0002_5555);
    run("div_m7_by_3",  32'hFFF9_0000, 32'h0003_0000, 1'b0, '0, '0);
    check("div_m7_by_3_exact", 64'(quotient), 64'hFFFD_AAAB);
    run("div0_pos",     32'h0001_0000, 32'h0000_0000, 1'b0, '0, '0);
    check("div0_pos_exact", 64'(quotient), 64'h7FFF_FFFF);
    run("div0_neg",     32'hFFFF_0000, 32'h0000_0000, 1'b0, '0, '0);
    check("div0_neg_exact", 64'(quotient), 64'h8000_0000);
    run("div0_zero",    32'h0000_0000, 32'h0000_0000, 1'b0, '0, '0);
    run("zero_by_neg",  32'h0000_0000, 32'hFFFE_0000, 1'b0, '0, '0);
    run("ovf_pos",      32'h7FFF_0000, 32'h0000_0001, 1'b0, '0, '0);
    check("ovf_pos_warn", 64'(warn), 64'd1);
    run("min_by_one",   32'h8000_0000, 32'h0001_0000, 1'b0, '0, '0);
    run("min_by_mone",  32'h8000_0000, 32'hFFFF_0000, 1'b0, '0, '0);
    run("mid_change",   32'h0005_0000, 32'h0004_0000, 1'b1, 32'hFFF6_0000, 32'h0003_0000);
    run("after_change", 32'hFFF6_0000, 32'h0003_0000, 1'b0, '0, '0);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      ra = $signed(ra) >>> $urandom_range(0, 31);
      rb = $urandom;
      if ($urandom_range(0, 2) == 0) rb = $signed(rb) >>> $urandom_range(8, 31);
      if ($urandom_range(0, 15) == 0) rb = '0;
      run("random", ra, rb, 1'b0, '0, '0);
    end

    run("pre_reset",    32'hFFFF_0000, 32'h0000_0000, 1'b0, '0, '0);
    dividend = 32'h0003_0000;
    divisor  = 32'h0001_0000;
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy_before_reset", 64'(busy), 64'd1);
    rst_n = 1'b1;
    #1;
    check("midrst_quotient", 64'(quotient), 64'd0);
    check("midrst_warn", 64'(warn), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_held_valid", 64'(valid), 64'd0);
    check("midrst_held_busy", 64'(busy), 64'd0);
    rst_n  = 1'b0;
    prev_q = '0;
    prev_w = 1'b0;
    run("after_reset",  32'h0009_0000, 32'hFFFD_0000, 1'b0, '0, '0);
    check("after_reset_exact", 64'(quotient), 64'hFFFD_0000);

    check("valid_busy_overlap", 64'(overlap), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
